// File: rtl/sdc_spi_pkg.sv
// rtl/sdc_spi_pkg.sv - shared constants, state enum and byte-order helper for the SPI target
package sdc_spi_pkg;

  localparam int          FRAME_NARROW = 8;
  localparam int          FRAME_WIDE   = 32;
  localparam logic [31:0] IDLE_FILL    = 32'hFFFF_FFFF;
  localparam int          SYNC_DEPTH   = 2;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } spi_state_t;

  // Bytes go out least-significant first, MSB-first within each byte, so a
  // left-shifting register wants byte 0 on top.
  function automatic logic [31:0] frame_order(input logic [31:0] w);
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction

endpackage

// File: rtl/sdc_spi_sync.sv
// rtl/sdc_spi_sync.sv - multi-flop synchronizer with configurable reset value
module sdc_spi_sync
  import sdc_spi_pkg::*;
#(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [SYNC_DEPTH-1:0] ff;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ff <= {SYNC_DEPTH{RST_VAL}};
    end else begin
      ff <= {ff[SYNC_DEPTH-2:0], d};
    end
  end

  assign q = ff[SYNC_DEPTH-1];

endmodule

// File: rtl/sdc_spi_target.sv
// rtl/sdc_spi_target.sv - oversampled SPI mode-0 target; SDC_SPI_TARGET_WIDE_EN adds 32-bit frames via fast
module sdc_spi_target
  import sdc_spi_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        sclk,
  input  logic        mosi,
  input  logic        cs_n,
  output logic        miso,
`ifdef SDC_SPI_TARGET_WIDE_EN
  input  logic        fast,
`endif
  input  logic [31:0] txdata,
  input  logic        txvalid,
  output logic        txready,
  output logic [31:0] rxdata,
  output logic        rxvalid
);

`ifdef SDC_SPI_TARGET_WIDE_EN
  localparam int RW = FRAME_WIDE;
  localparam int CW = 5;
`else
  localparam int RW = FRAME_NARROW;
  localparam int CW = 3;
`endif
  localparam int IW = $clog2(RW);

  logic          sclk_s, mosi_s, cs_s;
  logic          sclk_d, cs_d;
  logic          sclk_rise, sclk_fall, cs_rise, cs_fall;
  spi_state_t    state, state_nx;
  logic          shifting;
  logic          load, last_bit, last_seen;
  logic [CW-1:0] bitcnt;
  logic [RW-1:0] txbuf, tx_word, txshreg;
  logic          txfull;
  logic [RW-1:0] rxshreg, rx_next, rxdata_q;
  logic [IW-1:0] rx_idx;
`ifdef SDC_SPI_TARGET_WIDE_EN
  logic          wide_q;
`else
  logic          unused_txhi;
  assign unused_txhi = ^txdata[31:8];
`endif

  sdc_spi_sync #(.RST_VAL(1'b0)) u_sync_sclk (.clk(clk), .rst_n(rst_n), .d(sclk), .q(sclk_s));
  sdc_spi_sync #(.RST_VAL(1'b1)) u_sync_mosi (.clk(clk), .rst_n(rst_n), .d(mosi), .q(mosi_s));
  sdc_spi_sync #(.RST_VAL(1'b1)) u_sync_cs   (.clk(clk), .rst_n(rst_n), .d(cs_n), .q(cs_s));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_d <= 1'b0;
      cs_d   <= 1'b1;
    end else begin
      sclk_d <= sclk_s;
      cs_d   <= cs_s;
    end
  end

  assign sclk_rise = sclk_s & ~sclk_d;
  assign sclk_fall = ~sclk_s & sclk_d;
  assign cs_rise   = cs_s & ~cs_d;
  assign cs_fall   = ~cs_s & cs_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE:  if (cs_fall) state_nx = ST_SHIFT;
      ST_SHIFT: if (cs_rise) state_nx = ST_IDLE;
      default:  state_nx = ST_IDLE;
    endcase
  end

  always_comb begin
    shifting = (state == ST_SHIFT);
  end

`ifdef SDC_SPI_TARGET_WIDE_EN
  assign last_bit = wide_q ? (bitcnt == CW'(FRAME_WIDE - 1)) : (bitcnt == CW'(FRAME_NARROW - 1));
  assign rx_idx   = {bitcnt[4:3], ~bitcnt[2:0]};
`else
  assign last_bit = (bitcnt == CW'(FRAME_NARROW - 1));
  assign rx_idx   = ~bitcnt;
`endif

  // Next frame starts on select, or on the trailing sclk fall of a completed frame.
  assign load    = cs_fall | (shifting & sclk_fall & last_seen & ~cs_s);
  assign tx_word = txfull ? txbuf : RW'(IDLE_FILL);

  always_comb begin
    rx_next         = rxshreg;
    rx_next[rx_idx] = mosi_s;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      txbuf     <= '0;
      txfull    <= 1'b0;
      txshreg   <= '1;
      bitcnt    <= '0;
      last_seen <= 1'b0;
      rxshreg   <= '0;
      rxdata_q  <= '0;
      rxvalid   <= 1'b0;
`ifdef SDC_SPI_TARGET_WIDE_EN
      wide_q    <= 1'b0;
`endif
    end else begin
      rxvalid <= 1'b0;
      if (txvalid && !txfull) begin
        txbuf  <= txdata[RW-1:0];
        txfull <= 1'b1;
      end
      if (cs_rise) begin
        bitcnt    <= '0;
        last_seen <= 1'b0;
        txshreg   <= '1;
      end else if (load) begin
        if (txfull) txfull <= 1'b0;
        bitcnt    <= '0;
        last_seen <= 1'b0;
`ifdef SDC_SPI_TARGET_WIDE_EN
        wide_q  <= fast;
        txshreg <= frame_order(fast ? tx_word : {IDLE_FILL[31:8], tx_word[7:0]});
`else
        txshreg <= tx_word;
`endif
      end else if (shifting && sclk_rise) begin
        rxshreg <= rx_next;
        bitcnt  <= bitcnt + CW'(1);
        if (last_bit) begin
          rxvalid   <= 1'b1;
          last_seen <= 1'b1;
`ifdef SDC_SPI_TARGET_WIDE_EN
          rxdata_q  <= wide_q ? rx_next : {24'h0, rx_next[7:0]};
`else
          rxdata_q  <= rx_next;
`endif
        end
      end else if (shifting && sclk_fall && !last_seen) begin
        txshreg <= {txshreg[RW-2:0], 1'b1};
      end
    end
  end

  assign miso    = cs_n | txshreg[RW-1];
  assign txready = ~txfull;
`ifdef SDC_SPI_TARGET_WIDE_EN
  assign rxdata  = rxdata_q;
`else
  assign rxdata  = {24'h0, rxdata_q};
`endif

endmodule

// File: tb/tb_sdc_spi_target.sv
// tb/tb_sdc_spi_target.sv - directed self-checking bench for sdc_spi_target
module tb_sdc_spi_target;

  logic        clk = 1'b0;
  logic        rst_n, sclk, mosi, cs_n, txvalid;
  logic [31:0] txdata;
  logic        miso, txready, rxvalid;
  logic [31:0] rxdata;
`ifdef SDC_SPI_TARGET_WIDE_EN
  logic        fast;
`endif

  int tests   = 0;
  int fails   = 0;
  int rxv_cnt = 0;
  int base;
  logic [7:0] r0, r1, r2, r3;
  logic       rb;

  sdc_spi_target dut (
    .clk(clk), .rst_n(rst_n), .sclk(sclk), .mosi(mosi), .cs_n(cs_n), .miso(miso),
`ifdef SDC_SPI_TARGET_WIDE_EN
    .fast(fast),
`endif
    .txdata(txdata), .txvalid(txvalid), .txready(txready),
    .rxdata(rxdata), .rxvalid(rxvalid)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (rxvalid === 1'b1) rxv_cnt++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic spi_bit(input logic b, output logic r);
    mosi = b;
    repeat (8) @(negedge clk);
    r = miso;
    sclk = 1'b1;
    repeat (8) @(negedge clk);
    sclk = 1'b0;
  endtask

  task automatic spi_byte(input logic [7:0] tx, output logic [7:0] rx);
    logic b;
    for (int i = 7; i >= 0; i--) begin
      spi_bit(tx[i], b);
      rx[i] = b;
    end
  endtask

  task automatic write_tx(input logic [31:0] d);
    @(negedge clk);
    txdata  = d;
    txvalid = 1'b1;
    @(negedge clk);
    txvalid = 1'b0;
  endtask

  task automatic cs_low();
    cs_n = 1'b0;
    repeat (6) @(negedge clk);
  endtask

  task automatic cs_high();
    repeat (4) @(negedge clk);
    cs_n = 1'b1;
    repeat (6) @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0; sclk = 1'b0; mosi = 1'b1; cs_n = 1'b1;
    txvalid = 1'b0; txdata = '0;
`ifdef SDC_SPI_TARGET_WIDE_EN
    fast = 1'b0;
`endif
    repeat (3) @(negedge clk);
    chk("reset_miso", {31'h0, miso}, 32'h1);
    chk("reset_txready", {31'h0, txready}, 32'h1);
    chk("reset_rxvalid", {31'h0, rxvalid}, 32'h0);
    chk("reset_rxdata", rxdata, 32'h0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // buffered narrow transfer
    write_tx(32'h5A);
    chk("t1_txready_full", {31'h0, txready}, 32'h0);
    base = rxv_cnt;
    cs_low();
    chk("t1_txready_after_load", {31'h0, txready}, 32'h1);
    spi_byte(8'hC3, r0);
    repeat (4) @(negedge clk);
    chk("t1_host_rx", {24'h0, r0}, 32'h5A);
    chk("t1_rxdata", rxdata, 32'h0000_00C3);
    chk("t1_rxvalid_pulses", rxv_cnt - base, 1);
    cs_high();

    // empty buffer sends idle fill
    base = rxv_cnt;
    cs_low();
    spi_byte(8'h00, r0);
    repeat (4) @(negedge clk);
    chk("t2_host_rx", {24'h0, r0}, 32'hFF);
    chk("t2_rxdata", rxdata, 32'h0);
    chk("t2_rxvalid_pulses", rxv_cnt - base, 1);
    cs_high();

    // back-to-back frames with cs_n held low
    write_tx(32'h11);
    base = rxv_cnt;
    cs_low();
    write_tx(32'h22);
    chk("t3_txready_buffered", {31'h0, txready}, 32'h0);
    spi_byte(8'h3C, r1);
    spi_byte(8'h96, r2);
    repeat (4) @(negedge clk);
    chk("t3_host_rx0", {24'h0, r1}, 32'h11);
    chk("t3_host_rx1", {24'h0, r2}, 32'h22);
    chk("t3_rxdata", rxdata, 32'h96);
    chk("t3_rxvalid_pulses", rxv_cnt - base, 2);
    chk("t3_txready_end", {31'h0, txready}, 32'h1);
    cs_high();

    // abort after 5 bits, then a full frame
    base = rxv_cnt;
    cs_low();
    for (int i = 0; i < 5; i++) spi_bit(1'b1, rb);
    cs_high();
    chk("t4_abort_no_rxvalid", rxv_cnt - base, 0);
    chk("t4_abort_rxdata_kept", rxdata, 32'h96);
    cs_low();
    spi_byte(8'hA5, r0);
    repeat (4) @(negedge clk);
    chk("t4_host_rx", {24'h0, r0}, 32'hFF);
    chk("t4_rxdata", rxdata, 32'hA5);
    chk("t4_rxvalid_pulses", rxv_cnt - base, 1);
    cs_high();

`ifdef SDC_SPI_TARGET_WIDE_EN
    // 32-bit frame
    fast = 1'b1;
    write_tx(32'h4433_2211);
    base = rxv_cnt;
    cs_low();
    spi_byte(8'hDE, r0);
    spi_byte(8'hAD, r1);
    spi_byte(8'hBE, r2);
    spi_byte(8'hEF, r3);
    repeat (4) @(negedge clk);
    chk("t5_host_rx", {r3, r2, r1, r0}, 32'h4433_2211);
    chk("t5_rxdata", rxdata, 32'hEFBE_ADDE);
    chk("t5_rxvalid_pulses", rxv_cnt - base, 1);
    cs_high();
    fast = 1'b0;
`endif

    // reset mid-frame
    cs_low();
    write_tx(32'h77);
    for (int i = 0; i < 3; i++) spi_bit(1'b0, rb);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("t6_rst_miso", {31'h0, miso}, 32'h1);
    chk("t6_rst_txready", {31'h0, txready}, 32'h1);
    chk("t6_rst_rxvalid", {31'h0, rxvalid}, 32'h0);
    chk("t6_rst_rxdata", rxdata, 32'h0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    cs_n = 1'b1;
    repeat (6) @(negedge clk);
    base = rxv_cnt;
    cs_low();
    spi_byte(8'h3E, r0);
    repeat (4) @(negedge clk);
    chk("t6_host_rx", {24'h0, r0}, 32'hFF);
    chk("t6_rxdata", rxdata, 32'h3E);
    chk("t6_rxvalid_pulses", rxv_cnt - base, 1);
    cs_high();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
